aes_key_schedule: RTL
=====================

Name: aes_key_schedule

Overview:
Sequential AES-128 key-expansion stage that sits directly upstream of the encrypt round datapath. From a loaded cipher key it emits round keys 0..NR, one per valid/ready handshake, to the round controller. Round key 0 feeds the init (AddRoundKey-only) round, keys 1..NR-1 feed the full rounds, and key NR feeds the last round. One next-key computation per accepted key, so only one 128-bit key register and 4 S-box instances are needed.

Parameters:
NR, 10, number of rounds; legal range 1..10; default gives standard AES-128.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
start  in  1  load key_in and begin a schedule; sampled only in IDLE
key_in  in  128  cipher key; byte 0 at [127:120], word w0 = [127:96]
busy  out  1  high from the cycle after start is accepted until the cycle done pulses
key_valid  out  1  round_key/round_idx hold a valid round key
key_ready  in  1  consumer accepts round_key this cycle when key_valid=1
round_key  out  128  current round key, same byte order as key_in
round_idx  out  4  index of round_key, 0..NR
done  out  1  one-cycle pulse after round key NR is accepted

Behaviour:
- Reset (async assert, sync release): state=IDLE, busy=0, key_valid=0, done=0, round_idx=0, round_key=0.
- States: IDLE, EMIT.
- IDLE, start=1 at an edge: round_key<=key_in, round_idx<=0, key_valid<=1, busy<=1, go to EMIT. start=0 keeps IDLE. done is 0 in every IDLE cycle except the exit cycle defined below.
- EMIT, key_valid=1, key_ready=0: round_key and round_idx hold stable, with no limit on stall length.
- EMIT, handshake (key_valid & key_ready), round_idx<NR: round_key<=next(round_key, rcon[round_idx+1]), round_idx<=round_idx+1. key_valid stays 1, so back-to-back keys come one per cycle.
- EMIT, handshake, round_idx==NR: key_valid<=0, busy<=0, done<=1 for exactly one cycle, go to IDLE. round_key and round_idx keep their last values.
- next(): w0..w3 = current words. t = SubWord(RotWord(w3)) ^ {rcon,24'h0}. w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'. RotWord {a,b,c,d}->{b,c,d,a}. SubWord uses the standard AES forward S-box. rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- Latency: first key is visible on the cycle after start. All NR+1 keys take NR+1 cycles with key_ready tied high.
- start while busy is ignored and does not disturb the schedule. start in the same cycle done asserts is also ignored; a new start is accepted from the next cycle.
- key_in is sampled only at the accepting edge and may change afterwards.
- Reset mid-schedule: outputs return to reset values immediately, with no done pulse.
- All outputs are registered. There is no combinational path from key_ready or start to any output.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, key_ready=1: idx0 = key_in; idx1 = a0fafe1788542cb123a339392a6c7605; idx2 = f2c295f27a96b9435935807a7359f67f; idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6. done pulses once, on the cycle after idx10 is accepted.
- Backpressure: same key, drop key_ready for 5 cycles while idx=3. round_key stays 3d80477d4716fe3e1e237e446d7a883b and round_idx stays 3 throughout. After key_ready rises, idx4 follows on the next cycle.
- Random key_ready toggling over 1000 random keys: every emitted key matches the reference model; exactly 11 handshakes per schedule; idx strictly increments 0..10.
- Start while busy: pulse start with a different key_in at idx 5. Schedule continues unchanged and key_in is not reloaded. After done, a new start loads the new key and idx0 equals it.
- Async reset asserted mid-clock at idx 7: key_valid, busy, done and round_idx go to 0 before the next edge, with no done pulse. A fresh start after release yields the correct idx0/idx1.
- NR=1 build: FIPS key gives exactly two keys, idx0 = key_in and idx1 = a0fafe1788542cb123a339392a6c7605, then done.

Source files
------------

// File: rtl/aes_key_schedule.sv
// ---------------------------------------------------------------------------
// aes_key_schedule
//   Sequential AES-128 key expansion. A cipher key is loaded on start and the
//   round keys 0..NR are presented one at a time over a valid/ready handshake.
//   Each accepted key advances the single 128-bit key register by one
//   expansion step, using four forward S-box lookups.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   start      in   load key_in and begin a schedule (honoured only in IDLE)
//   key_in     in   128-bit cipher key, byte 0 at [127:120]
//   busy       out  schedule in progress
//   key_valid  out  round_key/round_idx hold a valid round key
//   key_ready  in   consumer accepts round_key when key_valid is high
//   round_key  out  current round key
//   round_idx  out  index of round_key, 0..NR
//   done       out  one-cycle pulse after round key NR is accepted
// ---------------------------------------------------------------------------
module aes_key_schedule #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         key_valid,
    input  logic         key_ready,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         done
);

    localparam logic [3:0] NR_L = 4'(NR);

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] base;
        // Entry b sits (255 - b) bytes above bit 0; 255 - b is simply ~b.
        base = {~b, 3'b000};
        return SBOX_TABLE[base +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [127:0]   round_key_q, round_key_d;
    logic [3:0]     round_idx_q, round_idx_d;
    logic           key_valid_q, key_valid_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    // Next-key datapath
    logic [31:0]    w0, w1, w2, w3;
    logic [31:0]    rot_w3;
    logic [31:0]    sub_w3;
    logic [31:0]    t_word;
    logic [31:0]    n0, n1, n2, n3;
    logic [3:0]     idx_inc;

    assign w0      = round_key_q[127:96];
    assign w1      = round_key_q[95:64];
    assign w2      = round_key_q[63:32];
    assign w3      = round_key_q[31:0];
    assign rot_w3  = {w3[23:0], w3[31:24]};
    assign idx_inc = round_idx_q + 4'd1;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sub
            assign sub_w3[31-8*gi -: 8] = sbox(rot_w3[31-8*gi -: 8]);
        end
    endgenerate

    assign t_word = sub_w3 ^ {rcon(idx_inc), 24'h000000};
    assign n0     = w0 ^ t_word;
    assign n1     = w1 ^ n0;
    assign n2     = w2 ^ n1;
    assign n3     = w3 ^ n2;

    always_comb begin
        state_d     = state_q;
        round_key_d = round_key_q;
        round_idx_d = round_idx_q;
        key_valid_d = key_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                // A start coinciding with the done pulse is dropped so the
                // consumer always sees at least one idle cycle between runs.
                if (start && !done_q) begin
                    round_key_d = key_in;
                    round_idx_d = 4'd0;
                    key_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = EMIT;
                end
            end
            EMIT: begin
                if (key_valid_q && key_ready) begin
                    if (round_idx_q == NR_L) begin
                        key_valid_d = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        round_key_d = {n0, n1, n2, n3};
                        round_idx_d = idx_inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            round_key_q <= '0;
            round_idx_q <= '0;
            key_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_key_q <= round_key_d;
            round_idx_q <= round_idx_d;
            key_valid_q <= key_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign key_valid = key_valid_q;
    assign round_key = round_key_q;
    assign round_idx = round_idx_q;
    assign done      = done_q;

endmodule
